// File: rtl/sram_bus_arbiter_pkg.sv
// Shared address map and FSM encoding for the two-master SRAM arbiter.
// Both SRAMs sit in a 4 MiB window selected by addr[31:22].
package sram_bus_arbiter_pkg;

    localparam logic [31:0] BASE_RAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] EXT_RAM_BASE    = 32'h8040_0000;
    localparam logic [31:0] RAM_REGION_MASK = 32'hFFC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_BASE,
        TGT_EXT
    } target_e;

    function automatic target_e decode_target(input logic [31:0] addr);
        if ((addr & RAM_REGION_MASK) == BASE_RAM_BASE) begin
            return TGT_BASE;
        end else if ((addr & RAM_REGION_MASK) == EXT_RAM_BASE) begin
            return TGT_EXT;
        end else begin
            return TGT_NONE;
        end
    endfunction

    function automatic logic [19:0] word_addr(input logic [31:0] addr);
        return addr[21:2];
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_sram_port.sv
// Registered pin driver for one asynchronous SRAM, including the data-bus tristate.
// When not selected the pins fall back to the idle pattern; address and write data hold.
module sram_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_d,
    input  logic        ce_n_d,
    input  logic        oe_n_d,
    input  logic        we_n_d,
    input  logic        drive_d,
    input  logic [3:0]  be_n_d,
    input  logic [19:0] addr_d,
    input  logic [31:0] wdata_d,
    output logic [31:0] rd_data,
    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        drive_q;
    logic [3:0]  be_n_q;
    logic [19:0] addr_q;
    logic [31:0] wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            be_n_q  <= 4'b1111;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (sel_d) begin
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
            be_n_q  <= be_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end else begin
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            be_n_q  <= 4'b1111;
        end
    end

    assign ram_data = drive_q ? wdata_q : 32'bz;
    assign rd_data  = ram_data;
    assign ram_addr = addr_q;
    assign ram_be_n = be_n_q;
    assign ram_ce_n = ce_n_q;
    assign ram_oe_n = oe_n_q;
    assign ram_we_n = we_n_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto two external SRAMs,
// one transaction at a time, with alternating priority and fully registered SRAM pins.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_e      state_q, state_d;
    target_e     tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_data_q, gnt_data_d;
    logic        last_data_q, last_data_d;
    logic [19:0] waddr_q, waddr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, data_rdata_q;
    logic        inst_ready_q, data_ready_q;

    logic        grant_inst, grant_data;
    logic [31:0] req_addr;
    logic        unused_addr_bits;

    logic        wr_d, access_d;
    logic        ce_n_d, oe_n_d, we_n_d;
    logic [3:0]  be_n_d;
    logic        base_sel_d, ext_sel_d;
    logic [31:0] base_rd, ext_rd, rd_bus;

    // Inst only takes priority right after a data grant; otherwise data wins.
    assign grant_inst = inst_req && (!data_req || last_data_q);
    assign grant_data = data_req && !grant_inst;
    assign req_addr   = grant_data ? data_addr : inst_addr;
    assign unused_addr_bits = ^req_addr[1:0];

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_inst || grant_data) begin
                    gnt_data_d  = grant_data;
                    last_data_d = grant_data;
                    waddr_d     = word_addr(req_addr);
                    we_d        = grant_data ? data_we : 4'b0000;
                    wdata_d     = grant_data ? data_wdata : 32'h0;
                    tgt_d       = decode_target(req_addr);
                    if (tgt_d == TGT_NONE) begin
                        state_d = S_DONE;
                    end else if (we_d != 4'b0000) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = CNT_INIT;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = S_WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so the pin registers line up with the FSM.
    always_comb begin
        wr_d       = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
        access_d   = (state_d == S_RD) || wr_d;
        ce_n_d     = !access_d;
        oe_n_d     = (state_d != S_RD);
        we_n_d     = (state_d != S_WR_PULSE);
        be_n_d     = wr_d ? ~we_d : (access_d ? 4'b0000 : 4'b1111);
        base_sel_d = access_d && (tgt_d == TGT_BASE);
        ext_sel_d  = access_d && (tgt_d == TGT_EXT);
    end

    assign rd_bus = (tgt_q == TGT_EXT) ? ext_rd : base_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tgt_q        <= TGT_NONE;
            cnt_q        <= '0;
            gnt_data_q   <= 1'b0;
            last_data_q  <= 1'b0;
            waddr_q      <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            gnt_data_q   <= gnt_data_d;
            last_data_q  <= last_data_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            inst_ready_q <= (state_d == S_DONE) && !gnt_data_d;
            data_ready_q <= (state_d == S_DONE) && gnt_data_d;
            if (state_d == S_DONE) begin
                if (state_q == S_RD) begin
                    if (gnt_data_q) data_rdata_q <= rd_bus;
                    else            inst_rdata_q <= rd_bus;
                end else if ((state_q == S_IDLE) && (we_d == 4'b0000)) begin
                    if (gnt_data_d) data_rdata_q <= '0;
                    else            inst_rdata_q <= '0;
                end
            end
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ready = inst_ready_q;
    assign data_ready = data_ready_q;

    sram_port u_base_port (
        .clk      (clk),
        .reset    (reset),
        .sel_d    (base_sel_d),
        .ce_n_d   (ce_n_d),
        .oe_n_d   (oe_n_d),
        .we_n_d   (we_n_d),
        .drive_d  (wr_d),
        .be_n_d   (be_n_d),
        .addr_d   (waddr_d),
        .wdata_d  (wdata_d),
        .rd_data  (base_rd),
        .ram_data (base_ram_data),
        .ram_addr (base_ram_addr),
        .ram_be_n (base_ram_be_n),
        .ram_ce_n (base_ram_ce_n),
        .ram_oe_n (base_ram_oe_n),
        .ram_we_n (base_ram_we_n)
    );

    sram_port u_ext_port (
        .clk      (clk),
        .reset    (reset),
        .sel_d    (ext_sel_d),
        .ce_n_d   (ce_n_d),
        .oe_n_d   (oe_n_d),
        .we_n_d   (we_n_d),
        .drive_d  (wr_d),
        .be_n_d   (be_n_d),
        .addr_d   (waddr_d),
        .wdata_d  (wdata_d),
        .rd_data  (ext_rd),
        .ram_data (ext_ram_data),
        .ram_addr (ext_ram_addr),
        .ram_be_n (ext_ram_be_n),
        .ram_ce_n (ext_ram_ce_n),
        .ram_oe_n (ext_ram_oe_n),
        .ram_we_n (ext_ram_we_n)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: dut0 (ACCESS_CYCLES=2) with two behavioural SRAMs, dut1 (ACCESS_CYCLES=1)
// with a read-only pattern SRAM for back-to-back reads.
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic mem_init;

    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_we;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_ready, data_ready;
    wire  [31:0] base_ram_data, ext_ram_data;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

    logic        inst_req1, data_req1;
    logic [31:0] inst_addr1, data_addr1, data_wdata1;
    logic [3:0]  data_we1;
    logic [31:0] inst_rdata1, data_rdata1;
    logic        inst_ready1, data_ready1;
    wire  [31:0] base_ram_data1, ext_ram_data1;
    logic [19:0] base_ram_addr1, ext_ram_addr1;
    logic [3:0]  base_ram_be_n1, ext_ram_be_n1;
    logic        base_ram_ce_n1, base_ram_oe_n1, base_ram_we_n1;
    logic        ext_ram_ce_n1, ext_ram_oe_n1, ext_ram_we_n1;

    sram_bus_arbiter #(.ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
    );

    sram_bus_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req1), .inst_addr(inst_addr1), .inst_rdata(inst_rdata1), .inst_ready(inst_ready1),
        .data_req(data_req1), .data_we(data_we1), .data_addr(data_addr1), .data_wdata(data_wdata1),
        .data_rdata(data_rdata1), .data_ready(data_ready1),
        .base_ram_data(base_ram_data1), .base_ram_addr(base_ram_addr1), .base_ram_be_n(base_ram_be_n1),
        .base_ram_ce_n(base_ram_ce_n1), .base_ram_oe_n(base_ram_oe_n1), .base_ram_we_n(base_ram_we_n1),
        .ext_ram_data(ext_ram_data1), .ext_ram_addr(ext_ram_addr1), .ext_ram_be_n(ext_ram_be_n1),
        .ext_ram_ce_n(ext_ram_ce_n1), .ext_ram_oe_n(ext_ram_oe_n1), .ext_ram_we_n(ext_ram_we_n1)
    );

    // Behavioural SRAMs for dut0: 256 words each, byte-enabled writes while we_n is low.
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    assign base_ram_data  = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] : 32'bz;
    assign ext_ram_data   = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'bz;
    assign base_ram_data1 = (!base_ram_ce_n1 && !base_ram_oe_n1) ? {12'hB00, base_ram_addr1} : 32'bz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                base_mem[i] <= (i == 4) ? 32'h1234_5678 : {24'hBA5E00, 8'(i)};
                ext_mem[i]  <= (i == 1) ? 32'h1122_3344 : {24'hE7E700, 8'(i)};
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
                    base_mem[base_ram_addr[7:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
                if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
                    ext_mem[ext_ram_addr[7:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          lat, base_oe_lo, ext_we_lo, strobe_lo;
    logic [3:0]  ext_be_seen;
    logic [19:0] ext_addr_seen;

    // Latency is counted in edges from the first edge after the call; 0 means timed out.
    task automatic wait_ready(input bit is_data);
        lat = 0; base_oe_lo = 0; ext_we_lo = 0; strobe_lo = 0;
        ext_be_seen = 4'hF; ext_addr_seen = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!base_ram_oe_n) base_oe_lo++;
            if (!ext_ram_we_n) begin
                ext_we_lo++;
                ext_be_seen   = ext_ram_be_n;
                ext_addr_seen = ext_ram_addr;
            end
            if (!base_ram_ce_n || !base_ram_oe_n || !base_ram_we_n ||
                !ext_ram_ce_n || !ext_ram_oe_n || !ext_ram_we_n) strobe_lo++;
            if (is_data ? data_ready : inst_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        logic [1:0] who;
        reset = 1'b1; mem_init = 1'b1;
        inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
        inst_req1 = 0; inst_addr1 = 0; data_req1 = 0; data_we1 = 0; data_addr1 = 0; data_wdata1 = 0;
        tick(); tick();
        reset = 1'b0; mem_init = 1'b0;

        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_data_rdata", data_rdata, 32'h0);
        check("rst_base_ce_n", 32'(base_ram_ce_n), 32'd1);
        check("rst_base_be_n", 32'(base_ram_be_n), 32'hF);
        check("rst_ext_addr", 32'(ext_ram_addr), 32'h0);

        // Fetch read from BaseRAM word 4
        inst_req = 1; inst_addr = 32'h8000_0010;
        wait_ready(1'b0);
        check("fetch_latency", lat, 32'd3);
        check("fetch_rdata", inst_rdata, 32'h1234_5678);
        check("fetch_oe_cycles", base_oe_lo, 32'd2);
        inst_req = 0;
        tick();
        check("fetch_ready_pulse", 32'(inst_ready), 32'd0);

        // Byte write to ExtRAM word 1, then read it back
        data_req = 1; data_we = 4'b0010; data_addr = 32'h8040_0004; data_wdata = 32'hAABB_CCDD;
        wait_ready(1'b1);
        check("bytewr_latency", lat, 32'd5);
        check("bytewr_we_cycles", ext_we_lo, 32'd2);
        check("bytewr_be_n", 32'(ext_be_seen), 32'hD);
        check("bytewr_addr", 32'(ext_addr_seen), 32'd1);
        data_we = 4'b0000;
        wait_ready(1'b1);
        check("bytewr_readback_latency", lat, 32'd4);
        check("bytewr_readback", data_rdata, 32'h1122_CC44);
        data_req = 0;
        tick();

        // Unmapped read
        data_req = 1; data_we = 4'b0000; data_addr = 32'h0000_1000;
        wait_ready(1'b1);
        check("unmapped_latency", lat, 32'd1);
        check("unmapped_rdata", data_rdata, 32'h0);
        check("unmapped_strobes", strobe_lo, 32'd0);
        data_req = 0;
        tick();

        // Both masters continuously requesting: D, I, D, I
        reset = 1; tick(); reset = 0;
        data_req = 1; data_we = 0; data_addr = 32'h8000_0000;
        inst_req = 1; inst_addr = 32'h8000_0004;
        for (int k = 0; k < 4; k++) begin
            who = 2'b00;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (data_ready || inst_ready) begin
                    who = {data_ready, inst_ready};
                    break;
                end
            end
            check($sformatf("arb_order_%0d", k), 32'(who), (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 0) check("arb_data_rdata", data_rdata, 32'hBA5E_0000);
            if (k == 1) check("arb_inst_rdata", inst_rdata, 32'hBA5E_0001);
        end
        data_req = 0; inst_req = 0;
        tick(); tick();

        // Reset during the write pulse
        data_req = 1; data_we = 4'b1111; data_addr = 32'h8000_0020; data_wdata = 32'hDEAD_BEEF;
        tick(); tick();
        check("rstwr_in_pulse_we_n", 32'(base_ram_we_n), 32'd0);
        reset = 1; data_req = 0;
        tick();
        reset = 0;
        check("rstwr_we_n", 32'(base_ram_we_n), 32'd1);
        check("rstwr_ce_n", 32'(base_ram_ce_n), 32'd1);
        check("rstwr_bus_drive", 32'(dut0.u_base_port.drive_q), 32'd0);
        check("rstwr_addr", 32'(base_ram_addr), 32'h0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_ready) dcnt++;
            tick();
        end
        check("rstwr_no_ready", dcnt, 32'd0);

        // ACCESS_CYCLES=1: back-to-back reads with data_req held high throughout
        data_req1 = 1; data_we1 = 0; data_addr1 = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (data_ready1) begin
                    lat = i;
                    break;
                end
            end
            check($sformatf("ac1_latency_%0d", k), lat, 32'd2);
            check($sformatf("ac1_rdata_%0d", k), data_rdata1, {12'hB00, 20'(k)});
            data_addr1 = 32'h8000_0000 + 32'(4 * (k + 1));
            tick();
            check($sformatf("ac1_single_ready_%0d", k), 32'(data_ready1), 32'd0);
        end
        data_req1 = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
